// File: rtl/dpram_pipelined_if.sv
// One request/response port of dpram_pipelined: request fields from the master,
// registered read data and strobe back from the RAM.
interface dpram_pipelined_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    logic                  en;
    logic                  we;
    logic [NUM_BYTES-1:0]  be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    modport master (output en, we, be, addr, wdata, input rdata, rvalid);
    modport slave  (input en, we, be, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/dpram_pipelined.sv
// Dual-port byte-enabled RAM with pipelined reads, fixed collision rules and a post-reset zero-fill.
// Define DPRAM_COLLISION_COUNT_EN to add the write/write collision pulse and saturating counter.
module dpram_pipelined #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    DEPTH          = 1024,
    parameter int    BYTE_WIDTH     = 8,
    parameter int    RD_LATENCY     = 1,
    parameter string RDW_MODE       = "READ_FIRST",
    parameter int    CLEAR_ON_RESET = 1,
    parameter string RAM_STYLE_VAL  = "block"
) (
    input  logic clock,
    input  logic reset,
    output logic init_busy,
    dpram_pipelined_if.slave port_a,
    dpram_pipelined_if.slave port_b
`ifdef DPRAM_COLLISION_COUNT_EN
    ,
    output logic        collision_o,
    output logic [15:0] collision_cnt
`endif
);

    localparam int NUM_BYTES   = DATA_WIDTH / BYTE_WIDTH;
    localparam int ADDR_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit WRITE_FIRST = (RDW_MODE == "WRITE_FIRST");
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    (* ram_style = RAM_STYLE_VAL *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  ready;
    logic                  in_range_a, in_range_b;
    logic                  rd_a, rd_b, wr_a, wr_b;
    logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;

    logic [DATA_WIDTH-1:0] pipe_data_a [RD_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_data_b [RD_LATENCY];
    logic [RD_LATENCY-1:0] pipe_valid_a, pipe_valid_b;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [NUM_BYTES-1:0]  be
    );
        logic [DATA_WIDTH-1:0] result;
        result = base;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (be[i]) result[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        return result;
    endfunction

    assign ready      = (state == ST_READY);
    assign init_busy  = (state == ST_CLEAR);
    assign in_range_a = (int'(port_a.addr) < DEPTH);
    assign in_range_b = (int'(port_b.addr) < DEPTH);
    assign rd_a       = ready & port_a.en & ~port_a.we;
    assign rd_b       = ready & port_b.en & ~port_b.we;
    assign wr_a       = ready & port_a.en & port_a.we & in_range_a;
    assign wr_b       = ready & port_b.en & port_b.we & in_range_b;

    // Out-of-range reads return zero; WRITE_FIRST folds the other port's lanes into the read word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        rd_word_a = '0;
        rd_word_b = '0;
        if (in_range_a) begin
            rd_word_a = mem[port_a.addr];
            if (WRITE_FIRST && wr_b && (port_b.addr == port_a.addr))
                rd_word_a = merge_lanes(rd_word_a, port_b.wdata, port_b.be);
        end
        if (in_range_b) begin
            rd_word_b = mem[port_b.addr];
            if (WRITE_FIRST && wr_a && (port_a.addr == port_b.addr))
                rd_word_b = merge_lanes(rd_word_b, port_a.wdata, port_a.be);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            if (clr_cnt == LAST_ADDR) state <= ST_READY;
            else                      clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // NOTE: the array itself has no reset; the CLEAR sequencer zeroes it so it still maps onto RAM macros.
    always_ff @(posedge clock) begin
        if (!ready) begin
            mem[clr_cnt] <= '0;
        end else begin
            // Port A is applied last in each lane so it wins overlapping lanes.
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_b && port_b.be[i])
                    mem[port_b.addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= port_b.wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (wr_a && port_a.be[i])
                    mem[port_a.addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= port_a.wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_valid_a <= '0;
            pipe_valid_b <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_data_a[i] <= '0;
                pipe_data_b[i] <= '0;
            end
        end else begin
            pipe_valid_a[0] <= rd_a;
            pipe_valid_b[0] <= rd_b;
            pipe_data_a[0]  <= rd_a ? rd_word_a : '0;
            pipe_data_b[0]  <= rd_b ? rd_word_b : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid_a[i] <= pipe_valid_a[i-1];
                pipe_valid_b[i] <= pipe_valid_b[i-1];
                pipe_data_a[i]  <= pipe_data_a[i-1];
                pipe_data_b[i]  <= pipe_data_b[i-1];
            end
        end
    end

    assign port_a.rdata  = pipe_data_a[RD_LATENCY-1];
    assign port_a.rvalid = pipe_valid_a[RD_LATENCY-1];
    assign port_b.rdata  = pipe_data_b[RD_LATENCY-1];
    assign port_b.rvalid = pipe_valid_b[RD_LATENCY-1];

`ifdef DPRAM_COLLISION_COUNT_EN
    logic collide;
    assign collide = wr_a & wr_b & (port_a.addr == port_b.addr) & (|(port_a.be & port_b.be));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            collision_o   <= 1'b0;
            collision_cnt <= '0;
        end else begin
            collision_o <= collide;
            if (collide && (collision_cnt != 16'hFFFF)) collision_cnt <= collision_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dpram_pipelined.sv
// Directed bench for dpram_pipelined: dut0 is DEPTH=16/latency 3/READ_FIRST,
// dut1 is DEPTH=12/latency 1/WRITE_FIRST; both share clock and reset.
module tb_dpram_pipelined;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   failed = 0;

    always #5 clock = ~clock;

    dpram_pipelined_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4)) a0 ();
    dpram_pipelined_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4)) b0 ();
    dpram_pipelined_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4)) a1 ();
    dpram_pipelined_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4)) b1 ();

    logic busy0, busy1;
`ifdef DPRAM_COLLISION_COUNT_EN
    logic        coll0, coll1;
    logic [15:0] ccnt0, ccnt1;
`endif

    dpram_pipelined #(
        .DATA_WIDTH(32), .DEPTH(16), .BYTE_WIDTH(8), .RD_LATENCY(3),
        .RDW_MODE("READ_FIRST"), .CLEAR_ON_RESET(1), .RAM_STYLE_VAL("block")
    ) dut0 (
        .clock(clock), .reset(reset), .init_busy(busy0), .port_a(a0), .port_b(b0)
`ifdef DPRAM_COLLISION_COUNT_EN
        , .collision_o(coll0), .collision_cnt(ccnt0)
`endif
    );

    dpram_pipelined #(
        .DATA_WIDTH(32), .DEPTH(12), .BYTE_WIDTH(8), .RD_LATENCY(1),
        .RDW_MODE("WRITE_FIRST"), .CLEAR_ON_RESET(1), .RAM_STYLE_VAL("distributed")
    ) dut1 (
        .clock(clock), .reset(reset), .init_busy(busy1), .port_a(a1), .port_b(b1)
`ifdef DPRAM_COLLISION_COUNT_EN
        , .collision_o(coll1), .collision_cnt(ccnt1)
`endif
    );

    function automatic int lat(input bit d);
        return d ? 1 : 3;
    endfunction

    task automatic set_req(input bit d, input bit p, input logic en, input logic we,
                           input logic [3:0] be, input logic [3:0] addr, input logic [31:0] wd);
        case ({d, p})
            2'b00: begin a0.en = en; a0.we = we; a0.be = be; a0.addr = addr; a0.wdata = wd; end
            2'b01: begin b0.en = en; b0.we = we; b0.be = be; b0.addr = addr; b0.wdata = wd; end
            2'b10: begin a1.en = en; a1.we = we; a1.be = be; a1.addr = addr; a1.wdata = wd; end
            default: begin b1.en = en; b1.we = we; b1.be = be; b1.addr = addr; b1.wdata = wd; end
        endcase
    endtask

    task automatic idle(input bit d);
        set_req(d, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        set_req(d, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic get_out(input bit d, input bit p, output logic [31:0] data, output logic valid);
        case ({d, p})
            2'b00: begin data = a0.rdata; valid = a0.rvalid; end
            2'b01: begin data = b0.rdata; valid = b0.rvalid; end
            2'b10: begin data = a1.rdata; valid = a1.rvalid; end
            default: begin data = b1.rdata; valid = b1.rvalid; end
        endcase
    endtask

    // One request cycle on both ports of a DUT, then wait out its read latency and sample.
    task automatic access2(input bit d,
                           input logic ea, input logic wea, input logic [3:0] bea,
                           input logic [3:0] aa, input logic [31:0] wa,
                           input logic eb, input logic web, input logic [3:0] beb,
                           input logic [3:0] ab, input logic [31:0] wb,
                           output logic [31:0] da, output logic va,
                           output logic [31:0] db, output logic vb);
        set_req(d, 1'b0, ea, wea, bea, aa, wa);
        set_req(d, 1'b1, eb, web, beb, ab, wb);
        @(negedge clock);
        idle(d);
        repeat (lat(d) - 1) @(negedge clock);
        get_out(d, 1'b0, da, va);
        get_out(d, 1'b1, db, vb);
    endtask

    task automatic write(input bit d, input bit p, input logic [3:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        logic [31:0] da, db;
        logic        va, vb;
        if (p) access2(d, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, be, addr, data, da, va, db, vb);
        else   access2(d, 1'b1, 1'b1, be, addr, data, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, da, va, db, vb);
    endtask

    task automatic read(input bit d, input bit p, input logic [3:0] addr,
                        output logic [31:0] data, output logic valid);
        logic [31:0] da, db;
        logic        va, vb;
        if (p) begin
            access2(d, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 4'h0, addr, 32'h0, da, va, db, vb);
            data = db; valid = vb;
        end else begin
            access2(d, 1'b1, 1'b0, 4'h0, addr, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, da, va, db, vb);
            data = da; valid = va;
        end
    endtask

    task automatic test_reset;
        logic [31:0] dt;
        logic        v;
        int          n0, n1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        for (int di = 0; di < 2; di++) begin
            for (int pi = 0; pi < 2; pi++) begin
                get_out(di[0], pi[0], dt, v);
                tests++;
                if (v !== 1'b0 || dt !== 32'h0) begin
                    failed++;
                    $display("FAIL reset_outputs d%0d p%0d: got v=%0b data=%h, expected v=0 data=00000000", di, pi, v, dt);
                end
            end
        end
        tests++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            failed++;
            $display("FAIL reset_busy: got %0b/%0b, expected 1/1", busy0, busy1);
        end
        reset = 1'b0;
        n0 = 0; n1 = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy0 === 1'b1) n0++;
            if (busy1 === 1'b1) n1++;
            @(negedge clock);
        end
        tests++;
        if (n0 != 16 || n1 != 12) begin
            failed++;
            $display("FAIL fill_length: got %0d/%0d busy cycles, expected 16/12", n0, n1);
        end
    endtask

    task automatic test_zero_fill;
        logic [31:0] dt;
        logic        v;
        for (int a = 0; a < 16; a++) begin
            read(1'b0, 1'b0, 4'(a), dt, v);
            tests++;
            if (v !== 1'b1 || dt !== 32'h0) begin
                failed++;
                $display("FAIL zero_fill d0 addr %0d: got v=%0b data=%h, expected v=1 data=00000000", a, v, dt);
            end
        end
        for (int a = 0; a < 12; a++) begin
            read(1'b1, 1'b1, 4'(a), dt, v);
            tests++;
            if (v !== 1'b1 || dt !== 32'h0) begin
                failed++;
                $display("FAIL zero_fill d1 addr %0d: got v=%0b data=%h, expected v=1 data=00000000", a, v, dt);
            end
        end
    endtask

    task automatic test_pipelined_reads;
        logic [31:0] dt, word, exp_d;
        logic        v, exp_v;
        for (int di = 0; di < 2; di++) begin
            word = di ? 32'h0BADF00D : 32'hDEADBEEF;
            write(di[0], 1'b0, 4'd5, word, 4'hF);
            for (int c = 0; c < 6; c++) begin
                if (c < 3) set_req(di[0], 1'b0, 1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
                else       idle(di[0]);
                @(negedge clock);
                get_out(di[0], 1'b0, dt, v);
                exp_v = (c >= lat(di[0]) - 1) && (c <= lat(di[0]) + 1);
                exp_d = exp_v ? word : 32'h0;
                tests++;
                if (v !== exp_v || dt !== exp_d) begin
                    failed++;
                    $display("FAIL pipelined_read d%0d cycle %0d: got v=%0b data=%h, expected v=%0b data=%h",
                             di, c, v, dt, exp_v, exp_d);
                end
            end
        end
    endtask

    task automatic test_collision;
        logic [31:0] dt, da, db;
        logic        v, va, vb;
        for (int di = 0; di < 2; di++) begin
            write(di[0], 1'b0, 4'd7, 32'h0, 4'hF);
            set_req(di[0], 1'b0, 1'b1, 1'b1, 4'b0011, 4'd7, 32'h11111111);
            set_req(di[0], 1'b1, 1'b1, 1'b1, 4'b0110, 4'd7, 32'h22222222);
            @(negedge clock);
            idle(di[0]);
`ifdef DPRAM_COLLISION_COUNT_EN
            tests++;
            if ((di ? coll1 : coll0) !== 1'b1) begin
                failed++;
                $display("FAIL collision_pulse d%0d: got %0b, expected 1", di, di ? coll1 : coll0);
            end
`endif
            @(negedge clock);
`ifdef DPRAM_COLLISION_COUNT_EN
            tests++;
            if ((di ? coll1 : coll0) !== 1'b0 || (di ? ccnt1 : ccnt0) !== 16'd1) begin
                failed++;
                $display("FAIL collision_count d%0d: got pulse=%0b cnt=%0d, expected pulse=0 cnt=1",
                         di, di ? coll1 : coll0, di ? ccnt1 : ccnt0);
            end
`endif
            read(di[0], 1'b1, 4'd7, dt, v);
            tests++;
            if (v !== 1'b1 || dt !== 32'h00221111) begin
                failed++;
                $display("FAIL ww_merge d%0d: got v=%0b data=%h, expected v=1 data=00221111", di, v, dt);
            end
            access2(di[0], 1'b1, 1'b1, 4'b0001, 4'd8, 32'h000000AA,
                    1'b1, 1'b1, 4'b1000, 4'd8, 32'hBB000000, da, va, db, vb);
            tests++;
            if (va !== 1'b0 || vb !== 1'b0) begin
                failed++;
                $display("FAIL write_no_rvalid d%0d: got %0b/%0b, expected 0/0", di, va, vb);
            end
            read(di[0], 1'b0, 4'd8, dt, v);
            tests++;
            if (v !== 1'b1 || dt !== 32'hBB0000AA) begin
                failed++;
                $display("FAIL ww_disjoint d%0d: got v=%0b data=%h, expected v=1 data=bb0000aa", di, v, dt);
            end
`ifdef DPRAM_COLLISION_COUNT_EN
            tests++;
            if ((di ? ccnt1 : ccnt0) !== 16'd1) begin
                failed++;
                $display("FAIL collision_disjoint d%0d: got cnt=%0d, expected 1", di, di ? ccnt1 : ccnt0);
            end
`endif
        end
    endtask

    task automatic test_read_during_write;
        logic [31:0] dt, da, db, exp;
        logic        v, va, vb;
        for (int di = 0; di < 2; di++) begin
            write(di[0], 1'b0, 4'd3, 32'hAAAAAAAA, 4'hF);
            access2(di[0], 1'b1, 1'b0, 4'h0, 4'd3, 32'h0,
                    1'b1, 1'b1, 4'hF, 4'd3, 32'h55555555, da, va, db, vb);
            exp = di ? 32'h55555555 : 32'hAAAAAAAA;
            tests++;
            if (va !== 1'b1 || da !== exp) begin
                failed++;
                $display("FAIL rdw_full d%0d: got v=%0b data=%h, expected v=1 data=%h", di, va, da, exp);
            end
            access2(di[0], 1'b1, 1'b0, 4'h0, 4'd3, 32'h0,
                    1'b1, 1'b1, 4'b0101, 4'd3, 32'h12345678, da, va, db, vb);
            exp = di ? 32'h55345578 : 32'h55555555;
            tests++;
            if (va !== 1'b1 || da !== exp) begin
                failed++;
                $display("FAIL rdw_partial d%0d: got v=%0b data=%h, expected v=1 data=%h", di, va, da, exp);
            end
            access2(di[0], 1'b1, 1'b1, 4'hF, 4'd3, 32'h0F0F0F0F,
                    1'b1, 1'b0, 4'h0, 4'd3, 32'h0, da, va, db, vb);
            exp = di ? 32'h0F0F0F0F : 32'h55345578;
            tests++;
            if (vb !== 1'b1 || db !== exp) begin
                failed++;
                $display("FAIL rdw_b_reads d%0d: got v=%0b data=%h, expected v=1 data=%h", di, vb, db, exp);
            end
            read(di[0], 1'b1, 4'd3, dt, v);
            tests++;
            if (v !== 1'b1 || dt !== 32'h0F0F0F0F) begin
                failed++;
                $display("FAIL rdw_after d%0d: got v=%0b data=%h, expected v=1 data=0f0f0f0f", di, v, dt);
            end
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] dt, da, db;
        logic        v, va, vb;
        for (int i = 0; i < 12; i++) write(1'b1, 1'b0, 4'(i), 32'hC0DE0000 + 32'(i), 4'hF);
        access2(1'b1, 1'b1, 1'b1, 4'hF, 4'd13, 32'hFFFFFFFF,
                1'b1, 1'b1, 4'hF, 4'd12, 32'hEEEEEEEE, da, va, db, vb);
        read(1'b1, 1'b1, 4'd13, dt, v);
        tests++;
        if (v !== 1'b1 || dt !== 32'h0) begin
            failed++;
            $display("FAIL oor_read13: got v=%0b data=%h, expected v=1 data=00000000", v, dt);
        end
        read(1'b1, 1'b0, 4'd12, dt, v);
        tests++;
        if (v !== 1'b1 || dt !== 32'h0) begin
            failed++;
            $display("FAIL oor_read12: got v=%0b data=%h, expected v=1 data=00000000", v, dt);
        end
        for (int i = 0; i < 12; i++) begin
            read(1'b1, 1'b0, 4'(i), dt, v);
            tests++;
            if (v !== 1'b1 || dt !== 32'hC0DE0000 + 32'(i)) begin
                failed++;
                $display("FAIL oor_inrange addr %0d: got v=%0b data=%h, expected v=1 data=%h",
                         i, v, dt, 32'hC0DE0000 + 32'(i));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] dt;
        logic        v;
        set_req(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 4'd9, 32'h13579BDF);
        @(negedge clock);
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        set_req(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd9, 32'h0);
        @(negedge clock);
        idle(1'b0);
        repeat (lat(1'b0) - 1) @(negedge clock);
        get_out(1'b0, 1'b1, dt, v);
        tests++;
        if (v !== 1'b1 || dt !== 32'h13579BDF) begin
            failed++;
            $display("FAIL b2b_a_to_b: got v=%0b data=%h, expected v=1 data=13579bdf", v, dt);
        end
        set_req(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'd10, 32'h2468ACE0);
        @(negedge clock);
        set_req(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'd10, 32'h0);
        @(negedge clock);
        idle(1'b1);
        get_out(1'b1, 1'b0, dt, v);
        tests++;
        if (v !== 1'b1 || dt !== 32'h2468ACE0) begin
            failed++;
            $display("FAIL b2b_b_to_a: got v=%0b data=%h, expected v=1 data=2468ace0", v, dt);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] dt;
        logic        v;
        int          n0, n1;
        bit          saw_rv;
        set_req(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
        @(negedge clock);
        idle(1'b0);
        repeat (lat(1'b0) - 1) @(negedge clock);
        get_out(1'b0, 1'b0, dt, v);
        tests++;
        if (v !== 1'b1 || dt !== 32'hDEADBEEF) begin
            failed++;
            $display("FAIL inflight_read: got v=%0b data=%h, expected v=1 data=deadbeef", v, dt);
        end
        reset = 1'b1;
        #1;
        get_out(1'b0, 1'b0, dt, v);
        tests++;
        if (v !== 1'b0 || dt !== 32'h0 || busy0 !== 1'b1) begin
            failed++;
            $display("FAIL reset_inflight: got v=%0b data=%h busy=%0b, expected v=0 data=00000000 busy=1", v, dt, busy0);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        tests++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            failed++;
            $display("FAIL reset_midclear_busy: got %0b/%0b, expected 1/1", busy0, busy1);
        end
        @(negedge clock);
        reset = 1'b0;
        n0 = 0; n1 = 0; saw_rv = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (busy0 === 1'b1) n0++;
            if (busy1 === 1'b1) n1++;
            if (a0.rvalid !== 1'b0 || b1.rvalid !== 1'b0) saw_rv = 1'b1;
            if (c == 5) begin
                set_req(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 4'd0, 32'hFFFFFFFF);
                set_req(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'd1, 32'hFFFFFFFF);
            end else if (c == 6) begin
                set_req(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd0, 32'h0);
                set_req(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'd1, 32'h0);
            end else begin
                idle(1'b0);
                idle(1'b1);
            end
            @(negedge clock);
        end
        tests++;
        if (n0 != 16 || n1 != 12 || saw_rv) begin
            failed++;
            $display("FAIL refill: got %0d/%0d busy cycles rvalid_seen=%0b, expected 16/12 rvalid_seen=0", n0, n1, saw_rv);
        end
        for (int k = 0; k < 3; k++) begin
            read(1'b0, 1'b0, (k == 0) ? 4'd0 : (k == 1) ? 4'd5 : 4'd9, dt, v);
            tests++;
            if (v !== 1'b1 || dt !== 32'h0) begin
                failed++;
                $display("FAIL refill_d0 probe %0d: got v=%0b data=%h, expected v=1 data=00000000", k, v, dt);
            end
            read(1'b1, 1'b1, (k == 0) ? 4'd1 : (k == 1) ? 4'd3 : 4'd11, dt, v);
            tests++;
            if (v !== 1'b1 || dt !== 32'h0) begin
                failed++;
                $display("FAIL refill_d1 probe %0d: got v=%0b data=%h, expected v=1 data=00000000", k, v, dt);
            end
        end
`ifdef DPRAM_COLLISION_COUNT_EN
        tests++;
        if (ccnt0 !== 16'd0 || ccnt1 !== 16'd0) begin
            failed++;
            $display("FAIL collision_cnt_reset: got %0d/%0d, expected 0/0", ccnt0, ccnt1);
        end
`endif
    endtask

    initial begin
        idle(1'b0);
        idle(1'b1);
        test_reset();
        test_zero_fill();
        test_pipelined_reads();
        test_collision();
        test_read_during_write();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached after %0d tests", tests);
        $fatal(1, "time limit reached");
    end

endmodule
